fifo_burst_drain: RTL and testbench

- Read-side drain controller that sits directly downstream of the synchronous FIFO.
- Watches the FIFO fill level, issues FIFO read enables in bursts and absorbs the FIFO's 1-cycle registered read latency in a 2-entry skid buffer.
- Presents the words on a valid/ready stream with a per-burst last marker.
- Consumers (DMA, serializer) see whole bursts instead of single-word trickle.

---
 rtl/fifo_burst_drain_if.sv | 29 ++
 rtl/fifo_burst_drain.sv | 166 ++++++++++++++++
 tb/tb_fifo_burst_drain.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_drain_if.sv
// FIFO read-side and output-stream signals of fifo_burst_drain.
// master = drain controller, slave = FIFO plus stream consumer.
interface fifo_burst_drain_if #(
    parameter int unsigned fifo_ptr  = 4,
    parameter int unsigned fifo_data = 32
);
    localparam int unsigned CW = fifo_ptr + 1;

    logic [CW-1:0]        data_avail;
    logic                 fifo_empty;
    logic [fifo_data-1:0] read_data;
    logic                 ren;
    logic                 flush;
    logic                 m_valid;
    logic                 m_ready;
    logic [fifo_data-1:0] m_data;
    logic                 m_last;
    logic                 busy;

    modport master (
        input  data_avail, fifo_empty, read_data, flush, m_ready,
        output ren, m_valid, m_data, m_last, busy
    );

    modport slave (
        output data_avail, fifo_empty, read_data, flush, m_ready,
        input  ren, m_valid, m_data, m_last, busy
    );
endinterface

// File: rtl/fifo_burst_drain.sv
// Burst read controller behind a synchronous FIFO with a 2-entry skid buffer.
// Optional idle-timeout partial-burst flush: define FIFO_BURST_TIMEOUT_EN.
module fifo_burst_drain #(
    parameter int unsigned fifo_ptr  = 4,
    parameter int unsigned fifo_data = 32,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic               clk,
    input  logic               rstb,
    fifo_burst_drain_if.master bus
);
    localparam int unsigned   CW    = fifo_ptr + 1;
    localparam logic [CW-1:0] BURST = CW'(BURST_LEN);

    if (BURST_LEN < 1 || BURST_LEN > (1 << fifo_ptr) || TIMEOUT < 1) begin : g_bad_cfg
        $error("fifo_burst_drain: BURST_LEN must be 1..2^fifo_ptr and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        TAIL  = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  target, target_n;
    logic [CW-1:0]  issued, issued_n;
    logic           flush_req, flush_req_n;
    logic           busy;
    logic           start;
    logic           pend, pend_last;
    logic           last_issue;
    logic           ren_c;
    logic           pop;
    logic           tmo_hit;
    logic [1:0]     occ;

    logic                 head_valid, head_last;
    logic [fifo_data-1:0] head_data;
    logic                 tail_valid, tail_last;
    logic [fifo_data-1:0] tail_data;

    assign occ        = 2'(head_valid) + 2'(tail_valid);
    assign pop        = head_valid & bus.m_ready;
    assign last_issue = (issued + CW'(1)) == target;

    // Read only when the word will have a skid slot on arrival; m_ready feeds ren combinationally.
    assign ren_c = (state == DRAIN) & ~bus.fifo_empty & (issued < target)
                 & ((3'(occ) + 3'(pend)) < (3'd2 + 3'(pop)));

    always_comb begin
        state_n     = state;
        target_n    = target;
        issued_n    = issued;
        flush_req_n = flush_req;
        start       = 1'b0;
        case (state)
            IDLE: begin
                start       = (bus.data_avail >= BURST) | (flush_req & ~bus.fifo_empty) | tmo_hit;
                flush_req_n = (flush_req | bus.flush) & ~bus.fifo_empty;
                if (start) begin
                    state_n     = DRAIN;
                    target_n    = (bus.data_avail < BURST) ? bus.data_avail : BURST;
                    issued_n    = '0;
                    flush_req_n = 1'b0;
                end
            end
            DRAIN: begin
                if (ren_c) issued_n = issued + CW'(1);
                if (issued_n == target) state_n = TAIL;
            end
            TAIL: begin
                if (!pend && (occ == 2'(pop))) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            target    <= '0;
            issued    <= '0;
            flush_req <= 1'b0;
            busy      <= 1'b0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            state     <= state_n;
            target    <= target_n;
            issued    <= issued_n;
            flush_req <= flush_req_n;
            busy      <= (state_n != IDLE);
            pend      <= ren_c;
            pend_last <= ren_c & last_issue;
        end
    end

    // Skid buffer: head drives the stream, tail holds the word that landed during a stall.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            head_valid <= 1'b0;
            head_last  <= 1'b0;
            head_data  <= '0;
            tail_valid <= 1'b0;
            tail_last  <= 1'b0;
            tail_data  <= '0;
        end else if (pop) begin
            if (tail_valid) begin
                head_valid <= 1'b1;
                head_last  <= tail_last;
                head_data  <= tail_data;
                tail_valid <= pend;
                if (pend) begin
                    tail_last <= pend_last;
                    tail_data <= bus.read_data;
                end
            end else begin
                head_valid <= pend;
                head_last  <= pend & pend_last;
                if (pend) head_data <= bus.read_data;
            end
        end else if (pend) begin
            if (!head_valid) begin
                head_valid <= 1'b1;
                head_last  <= pend_last;
                head_data  <= bus.read_data;
            end else begin
                tail_valid <= 1'b1;
                tail_last  <= pend_last;
                tail_data  <= bus.read_data;
            end
        end
    end

`ifdef FIFO_BURST_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_run;

    // Partial bursts waiting in IDLE are forced out after TIMEOUT cycles.
    assign tmo_run = (state == IDLE) & ~bus.fifo_empty & (bus.data_avail < BURST);
    assign tmo_hit = tmo_run & (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            tmo_cnt <= '0;
        end else if (!tmo_run || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign bus.ren     = ren_c;
    assign bus.m_valid = head_valid;
    assign bus.m_data  = head_data;
    assign bus.m_last  = head_last;
    assign bus.busy    = busy;

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: queue-based FIFO model plus burst-chunking reference.
module tb_fifo_burst_drain;
    localparam int unsigned PTR  = 4;
    localparam int unsigned AW   = PTR + 1;
    localparam int unsigned DW   = 32;
    localparam int unsigned BL   = 4;
    localparam int unsigned TMO  = 10;
    localparam int unsigned HIST = 8192;

    logic clk;
    logic rstb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fifo_burst_drain_if #(.fifo_ptr(PTR), .fifo_data(DW)) bus ();

    fifo_burst_drain #(
        .fifo_ptr (PTR),
        .fifo_data(DW),
        .BURST_LEN(BL),
        .TIMEOUT  (TMO)
    ) dut (
        .clk (clk),
        .rstb(rstb),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Upstream FIFO: registered count/empty, read data one cycle after ren.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] wr_q[$];
    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            fifo_q.delete();
            wr_q.delete();
            bus.data_avail <= '0;
            bus.fifo_empty <= 1'b1;
            bus.read_data  <= '0;
        end else begin
            if (bus.ren && fifo_q.size() > 0) bus.read_data <= fifo_q.pop_front();
            while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
            bus.data_avail <= AW'(fifo_q.size());
            bus.fifo_empty <= (fifo_q.size() == 0);
        end
    end

    int            cyc = 0;
    logic [DW-1:0] pop_d[$];
    logic          pop_l[$];
    int            pop_c[$];
    int            ren_c[$];
    int            empty_rd_err = 0;
    int            hold_err = 0;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] stall_data;
    logic          stall_last;
    logic          last_valid, last_busy, last_empty;
    logic [DW-1:0] last_data;
    bit            busy_hist [HIST];
    bit            rand_ready = 1'b0;
    int            ready_pct = 60;

    // Sample one cycle just after the negedge, then advance to the next negedge.
    task automatic tick();
        #1;
        if (bus.ren && bus.fifo_empty) empty_rd_err++;
        if (stall_prev && (!bus.m_valid || bus.m_data !== stall_data || bus.m_last !== stall_last))
            hold_err++;
        stall_prev = bus.m_valid && !bus.m_ready;
        stall_data = bus.m_data;
        stall_last = bus.m_last;
        if (bus.ren) ren_c.push_back(cyc);
        if (bus.m_valid && bus.m_ready) begin
            pop_d.push_back(bus.m_data);
            pop_l.push_back(bus.m_last);
            pop_c.push_back(cyc);
        end
        if (cyc < HIST) busy_hist[cyc] = bus.busy;
        last_valid = bus.m_valid;
        last_data  = bus.m_data;
        last_busy  = bus.busy;
        last_empty = bus.fifo_empty;
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_rec();
        pop_d.delete();
        pop_l.delete();
        pop_c.delete();
        ren_c.delete();
    endtask

    task automatic load(input logic [DW-1:0] w[$]);
        foreach (w[i]) wr_q.push_back(w[i]);
    endtask

    task automatic run_until(input int n, input int budget, output bit ok);
        int k = 0;
        while (pop_d.size() < n && k < budget) begin
            if (rand_ready) bus.m_ready = ($urandom_range(0, 99) < ready_pct);
            tick();
            k++;
        end
        ok = (pop_d.size() >= n);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int k = 0;
        tick();
        while (last_busy && k < budget) begin
            if (rand_ready) bus.m_ready = ($urandom_range(0, 99) < ready_pct);
            tick();
            k++;
        end
        ok = !last_busy;
    endtask

    // Reference: words leave in write order, split into BURST_LEN chunks plus one remainder chunk.
    function automatic bit exp_last(input int i, input int n);
        return ((i + 1) % BL == 0) || (i == n - 1);
    endfunction

    task automatic compare_stream(input string tag, input logic [DW-1:0] w[$]);
        logic [DW-1:0] gd;
        logic          gl;
        for (int i = 0; i < w.size(); i++) begin
            gd = (i < pop_d.size()) ? pop_d[i] : 'x;
            gl = (i < pop_l.size()) ? pop_l[i] : 1'bx;
            n_tests++;
            if (gd !== w[i] || gl !== exp_last(i, w.size())) begin
                n_fail++;
                $display("FAIL %s_word%0d: got %h last=%b, want %h last=%b",
                         tag, i, gd, gl, w[i], exp_last(i, w.size()));
            end
        end
        n_tests++;
        if (pop_d.size() != w.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d words, want %0d", tag, pop_d.size(), w.size());
        end
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        bus.flush = 1'b0;
        bus.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if (bus.ren !== 1'b0)     begin n_fail++; $display("FAIL reset_ren: got %b want 0", bus.ren); end
        n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
        n_tests++; if (bus.m_last !== 1'b0)  begin n_fail++; $display("FAIL reset_m_last: got %b want 0", bus.m_last); end
        n_tests++; if (bus.m_data !== '0)    begin n_fail++; $display("FAIL reset_m_data: got %h want 0", bus.m_data); end
        n_tests++; if (bus.busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        @(negedge clk);
        rstb = 1'b1;
        tick();
    endtask

    task automatic test_single_burst();
        logic [DW-1:0] w[$] = '{32'd1, 32'd2, 32'd3, 32'd4};
        bit ok;
        int p;
        clear_rec();
        bus.m_ready = 1'b1;
        load(w);
        run_until(4, 40, ok);
        repeat (3) tick();
        n_tests++; if (!ok) begin n_fail++; $display("FAIL single_done: got %0d pops want 4", pop_d.size()); end
        compare_stream("single", w);
        n_tests++;
        if (ren_c.size() != 4 || (ren_c[ren_c.size()-1] - ren_c[0]) != 3) begin
            n_fail++; $display("FAIL single_ren_run: got %0d ren cycles want 4 consecutive", ren_c.size());
        end
        if (ok && ren_c.size() > 0) begin
            n_tests++;
            if (pop_c[3] - pop_c[0] != 3 || pop_c[0] - ren_c[0] != 2) begin
                n_fail++; $display("FAIL single_timing: got span %0d latency %0d want 3 and 2",
                                   pop_c[3] - pop_c[0], pop_c[0] - ren_c[0]);
            end
            p = pop_c[3];
            n_tests++;
            if (busy_hist[p] !== 1'b1 || busy_hist[p+1] !== 1'b0) begin
                n_fail++; $display("FAIL single_busy_fall: got %b,%b want 1,0", busy_hist[p], busy_hist[p+1]);
            end
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] w[$] = '{32'hA, 32'hB, 32'hC};
        bit ok;
        clear_rec();
        bus.m_ready = 1'b1;
        load(w);
`ifdef FIFO_BURST_TIMEOUT_EN
        repeat (5) tick();
`else
        repeat (40) tick();
`endif
        n_tests++;
        if (ren_c.size() != 0 || last_busy !== 1'b0 || pop_d.size() != 0) begin
            n_fail++; $display("FAIL flush_wait: got %0d ren busy=%b want 0 ren busy=0", ren_c.size(), last_busy);
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        run_until(3, 30, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL flush_done: got %0d pops want 3", pop_d.size()); end
        wait_idle(20, ok);
        compare_stream("flush", w);
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w[$] = '{32'd1, 32'd2, 32'd3, 32'd4};
        bit ok;
        int k = 0;
        clear_rec();
        bus.m_ready = 1'b0;
        load(w);
        tick();
        while (!last_valid && k < 20) begin tick(); k++; end
        n_tests++; if (!last_valid) begin n_fail++; $display("FAIL bp_first_valid: got m_valid=%b want 1", last_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (last_valid !== 1'b1 || last_data !== 32'd1) begin
                n_fail++; $display("FAIL bp_hold%0d: got valid=%b data=%h want 1 and 1", i, last_valid, last_data);
            end
        end
        n_tests++; if (ren_c.size() != 2) begin n_fail++; $display("FAIL bp_ren_count: got %0d want 2", ren_c.size()); end
        bus.m_ready = 1'b1;
        run_until(4, 40, ok);
        wait_idle(20, ok);
        compare_stream("bp", w);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] w[$];
        bit ok;
        clear_rec();
        for (int i = 0; i < 8; i++) w.push_back($urandom());
        bus.m_ready = 1'b1;
        load(w);
        run_until(8, 80, ok);
        wait_idle(20, ok);
        repeat (2) tick();
        compare_stream("b2b", w);
        n_tests++;
        if (bus.data_avail !== '0 || bus.fifo_empty !== 1'b1) begin
            n_fail++; $display("FAIL b2b_fifo_end: got avail=%0d empty=%b want 0 and 1", bus.data_avail, bus.fifo_empty);
        end
    endtask

`ifdef FIFO_BURST_TIMEOUT_EN
    task automatic test_timeout();
        logic [DW-1:0] w[$] = '{32'h11, 32'h22};
        bit ok;
        int k = 0;
        int fall, enter;
        clear_rec();
        bus.m_ready = 1'b1;
        load(w);
        tick();
        while (last_empty && k < 10) begin tick(); k++; end
        fall = cyc - 1;
        k = 0;
        while (!last_busy && k < 40) begin tick(); k++; end
        enter = cyc - 1;
        n_tests++;
        if (!last_busy || enter - fall != TMO) begin
            n_fail++; $display("FAIL timeout_entry: got %0d cycles want %0d", enter - fall, TMO);
        end
        run_until(2, 30, ok);
        wait_idle(20, ok);
        compare_stream("timeout", w);
    endtask
`endif

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [DW-1:0] w[$];
            bit ok;
            int n, r;
            clear_rec();
            n = $urandom_range(1, 12);
            r = n % BL;
            for (int i = 0; i < n; i++) w.push_back($urandom());
            rand_ready = 1'b1;
            ready_pct = $urandom_range(30, 90);
            load(w);
            run_until(n - r, 400, ok);
            wait_idle(40, ok);
`ifndef FIFO_BURST_TIMEOUT_EN
            bus.flush = 1'b1;
            tick();
            bus.flush = 1'b0;
`endif
            run_until(n, 400, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL rand%0d_done: got %0d pops want %0d", it, pop_d.size(), n); end
            wait_idle(40, ok);
            if (r == 0) begin
                bus.flush = 1'b1;
                tick();
                bus.flush = 1'b0;
                repeat (6) tick();
                n_tests++;
                if (last_busy !== 1'b0 || ren_c.size() != n) begin
                    n_fail++; $display("FAIL rand%0d_empty_flush: got busy=%b ren=%0d want 0 and %0d",
                                       it, last_busy, ren_c.size(), n);
                end
            end
            rand_ready = 1'b0;
            bus.m_ready = 1'b1;
            compare_stream($sformatf("rand%0d", it), w);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] w[$] = '{32'h51, 32'h52, 32'h53, 32'h54};
        logic [DW-1:0] v[$] = '{32'h61, 32'h62, 32'h63};
        logic [DW-1:0] x[$] = '{32'h64};
        bit ok;
        clear_rec();
        bus.m_ready = 1'b1;
        load(w);
        run_until(2, 40, ok);
        #3 rstb = 1'b0;
        #1;
        n_tests++;
        if (bus.m_valid !== 1'b0 || bus.ren !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async: got valid=%b ren=%b busy=%b want 0,0,0", bus.m_valid, bus.ren, bus.busy);
        end
        @(negedge clk);
        rstb = 1'b1;
        stall_prev = 1'b0;
        clear_rec();
        load(v);
`ifdef FIFO_BURST_TIMEOUT_EN
        repeat (6) tick();
`else
        repeat (20) tick();
`endif
        n_tests++;
        if (pop_d.size() != 0 || ren_c.size() != 0 || last_busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_quiet: got pops=%0d ren=%0d busy=%b want 0,0,0", pop_d.size(), ren_c.size(), last_busy);
        end
        load(x);
        run_until(4, 40, ok);
        wait_idle(20, ok);
        v.push_back(x[0]);
        compare_stream("rstmid", v);
    endtask

    task automatic test_protocol();
        n_tests++; if (empty_rd_err != 0) begin n_fail++; $display("FAIL empty_read: got %0d reads of empty FIFO want 0", empty_rd_err); end
        n_tests++; if (hold_err != 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable stalled cycles want 0", hold_err); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_burst();
        test_flush();
        test_backpressure();
        test_back_to_back();
`ifdef FIFO_BURST_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        test_reset_mid();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
